// File: rtl/cmd_rw_arbiter_pkg.sv
`default_nettype none
//==============================================================================
// Package  : lpddr4_ctrl_pkg
// Brief    : Command payload, arbiter state and ACT decode shared across the
//            LPDDR4 controller command path.
// Revision : 1.0 - initial release
//==============================================================================
package lpddr4_ctrl_pkg;

    // Widest address fields carried by the payload struct
    localparam int CMD_ABITS  = 17;
    localparam int CMD_BABITS = 3;

    typedef struct packed {
        logic [CMD_ABITS-1:0]  a;
        logic [CMD_BABITS-1:0] ba;
        logic                  cas;
        logic                  ras;
        logic                  we;
        logic                  is_cmd;
        logic                  is_read;
        logic                  is_write;
        logic                  is_mw;
    } cmd_payload_t;

    typedef enum logic [1:0] {
        ARB     = 2'd0,
        DRAIN   = 2'd1,
        REFRESH = 2'd2
    } arb_state_e;

    function automatic logic is_activate(input cmd_payload_t p);
        return p.is_cmd & p.ras & ~p.cas & ~p.we;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_rw_arbiter_if.sv
`default_nettype none
//==============================================================================
// Interface: cmd_rw_arbiter_if
// Brief    : Per-requester command inputs, shared output command stream and
//            refresh ownership handshake of the command arbiter.
// Revision : 1.0 - initial release
//==============================================================================
interface cmd_rw_arbiter_if #(
    parameter int NREQ   = 8,
    parameter int ABITS  = 17,
    parameter int BABITS = 3
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*ABITS-1:0]  req_a;
    logic [NREQ*BABITS-1:0] req_ba;
    logic [NREQ-1:0]        req_cas;
    logic [NREQ-1:0]        req_ras;
    logic [NREQ-1:0]        req_we;
    logic [NREQ-1:0]        req_is_cmd;
    logic [NREQ-1:0]        req_is_read;
    logic [NREQ-1:0]        req_is_write;
    logic [NREQ-1:0]        req_is_mw;

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [ABITS-1:0]       cmd_payload_a;
    logic [BABITS-1:0]      cmd_payload_ba;
    logic                   cmd_payload_cas;
    logic                   cmd_payload_ras;
    logic                   cmd_payload_we;
    logic                   cmd_payload_is_cmd;
    logic                   cmd_payload_is_read;
    logic                   cmd_payload_is_write;
    logic                   cmd_payload_is_mw;

    logic                   refresh_req;
    logic                   refresh_gnt;

    // Environment side: bank machines, downstream mux and refresher
    modport master (
        output req_valid, req_a, req_ba, req_cas, req_ras, req_we,
               req_is_cmd, req_is_read, req_is_write, req_is_mw,
               cmd_ready, refresh_req,
        input  req_ready, cmd_valid, cmd_payload_a, cmd_payload_ba,
               cmd_payload_cas, cmd_payload_ras, cmd_payload_we,
               cmd_payload_is_cmd, cmd_payload_is_read,
               cmd_payload_is_write, cmd_payload_is_mw, refresh_gnt
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_a, req_ba, req_cas, req_ras, req_we,
               req_is_cmd, req_is_read, req_is_write, req_is_mw,
               cmd_ready, refresh_req,
        output req_ready, cmd_valid, cmd_payload_a, cmd_payload_ba,
               cmd_payload_cas, cmd_payload_ras, cmd_payload_we,
               cmd_payload_is_cmd, cmd_payload_is_read,
               cmd_payload_is_write, cmd_payload_is_mw, refresh_gnt
    );

endinterface
`default_nettype wire

// File: rtl/cmd_rw_arbiter_rr.sv
`default_nettype none
//==============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first requesting index after
//            last_grant_i, wrapping modulo N.
// Revision : 1.0 - initial release
//==============================================================================
module rr_arbiter #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_grant_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o
);

    logic [IW:0] cand;
    logic        found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        cand      = '0;
        found     = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand = {1'b0, last_grant_i} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!found && req_i[cand[IW-1:0]]) begin
                found                 = 1'b1;
                gnt_o[cand[IW-1:0]]   = 1'b1;
                gnt_idx_o             = cand[IW-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cmd_rw_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : cmd_rw_arbiter
// Brief    : Round-robin arbiter sharing one registered command stream among
//            NREQ bank machines, with tRRD/tFAW ACT gating and refresh drain.
// Revision : 1.0 - initial release
//==============================================================================
module cmd_rw_arbiter
    import lpddr4_ctrl_pkg::*;
#(
    parameter int NREQ   = 8,
    parameter int ABITS  = 17,
    parameter int BABITS = 3,
    parameter int TRRD   = 4,
    parameter int TFAW   = 16
) (
    input  logic              clk,
    input  logic              rst,
    cmd_rw_arbiter_if.slave   bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TRRD) + 1;
    localparam int HW = TFAW - 1;
    localparam int CW = $clog2(TFAW) + 3;

    cmd_payload_t    req_pay [NREQ];
    logic [NREQ-1:0] is_act;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] gnt_oh;
    logic [IW-1:0]   gnt_idx;
    logic            act_ok;
    logic            out_free;
    logic            grant_en;
    logic            act_gnt;
    logic [CW-1:0]   faw_cnt;

    arb_state_e      state_q, state_d;
    cmd_payload_t    pay_q, pay_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic            refresh_gnt_q, refresh_gnt_d;
    logic [IW-1:0]   last_grant_q, last_grant_d;
    logic [TW-1:0]   trrd_q, trrd_d;
    logic [HW-1:0]   faw_q, faw_d;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign req_pay[gi] = '{
                a:        CMD_ABITS'(bus.req_a[gi*ABITS +: ABITS]),
                ba:       CMD_BABITS'(bus.req_ba[gi*BABITS +: BABITS]),
                cas:      bus.req_cas[gi],
                ras:      bus.req_ras[gi],
                we:       bus.req_we[gi],
                is_cmd:   bus.req_is_cmd[gi],
                is_read:  bus.req_is_read[gi],
                is_write: bus.req_is_write[gi],
                is_mw:    bus.req_is_mw[gi]
            };
            assign is_act[gi] = is_activate(req_pay[gi]);
        end
    endgenerate

    always_comb begin
        faw_cnt = '0;
        for (int k = 0; k < HW; k++) begin
            faw_cnt = faw_cnt + {{(CW-1){1'b0}}, faw_q[k]};
        end
    end

    assign act_ok   = (trrd_q == '0) && (faw_cnt < CW'(4));
    // A blocked ACT drops out so requesters behind it can still win
    assign eligible = bus.req_valid & ~(is_act & {NREQ{~act_ok}});
    assign out_free = ~cmd_valid_q | bus.cmd_ready;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr (
        .req_i        (eligible),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt_oh),
        .gnt_idx_o    (gnt_idx)
    );

    always_comb begin
        state_d       = state_q;
        pay_d         = pay_q;
        cmd_valid_d   = cmd_valid_q;
        refresh_gnt_d = refresh_gnt_q;
        last_grant_d  = last_grant_q;
        grant_en      = 1'b0;
        case (state_q)
            ARB: begin
                if (bus.refresh_req) begin
                    state_d = DRAIN;
                    if (bus.cmd_ready) cmd_valid_d = 1'b0;
                end else if (out_free && (|eligible)) begin
                    grant_en     = 1'b1;
                    pay_d        = req_pay[gnt_idx];
                    cmd_valid_d  = 1'b1;
                    last_grant_d = gnt_idx;
                end else if (bus.cmd_ready) begin
                    cmd_valid_d = 1'b0;
                end
            end
            DRAIN: begin
                if (!bus.refresh_req) begin
                    state_d = ARB;
                    if (bus.cmd_ready) cmd_valid_d = 1'b0;
                end else if (!cmd_valid_q || bus.cmd_ready) begin
                    cmd_valid_d   = 1'b0;
                    refresh_gnt_d = 1'b1;
                    state_d       = REFRESH;
                end
            end
            REFRESH: begin
                cmd_valid_d = 1'b0;
                if (!bus.refresh_req) begin
                    refresh_gnt_d = 1'b0;
                    state_d       = ARB;
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    assign act_gnt = grant_en & is_act[gnt_idx];

    always_comb begin
        if (act_gnt) begin
            trrd_d = TW'(TRRD - 1);
        end else if (trrd_q != '0) begin
            trrd_d = trrd_q - TW'(1);
        end else begin
            trrd_d = '0;
        end
    end

    generate
        if (HW > 1) begin : g_faw_wide
            assign faw_d = {faw_q[HW-2:0], act_gnt};
        end else begin : g_faw_narrow
            assign faw_d = act_gnt;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ARB;
            pay_q         <= '0;
            cmd_valid_q   <= 1'b0;
            refresh_gnt_q <= 1'b0;
            last_grant_q  <= IW'(NREQ - 1);
            trrd_q        <= '0;
            faw_q         <= '0;
        end else begin
            state_q       <= state_d;
            pay_q         <= pay_d;
            cmd_valid_q   <= cmd_valid_d;
            refresh_gnt_q <= refresh_gnt_d;
            last_grant_q  <= last_grant_d;
            trrd_q        <= trrd_d;
            faw_q         <= faw_d;
        end
    end

    assign bus.req_ready            = (grant_en && !rst) ? gnt_oh : '0;
    assign bus.cmd_valid            = cmd_valid_q;
    assign bus.refresh_gnt          = refresh_gnt_q;
    assign bus.cmd_payload_a        = ABITS'(pay_q.a);
    assign bus.cmd_payload_ba       = BABITS'(pay_q.ba);
    assign bus.cmd_payload_cas      = pay_q.cas;
    assign bus.cmd_payload_ras      = pay_q.ras;
    assign bus.cmd_payload_we       = pay_q.we;
    assign bus.cmd_payload_is_cmd   = pay_q.is_cmd;
    assign bus.cmd_payload_is_read  = pay_q.is_read;
    assign bus.cmd_payload_is_write = pay_q.is_write;
    assign bus.cmd_payload_is_mw    = pay_q.is_mw;

endmodule
`default_nettype wire

// File: tb/tb_cmd_rw_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_cmd_rw_arbiter
// Brief    : Directed scoreboard bench for cmd_rw_arbiter (two timing configs).
// Revision : 1.0 - initial release
//==============================================================================
module tb_cmd_rw_arbiter;

    localparam int NREQ   = 8;
    localparam int ABITS  = 17;
    localparam int BABITS = 3;
    localparam int PW     = ABITS + BABITS + 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cmd_rw_arbiter_if #(.NREQ(NREQ), .ABITS(ABITS), .BABITS(BABITS)) bus ();
    cmd_rw_arbiter_if #(.NREQ(NREQ), .ABITS(ABITS), .BABITS(BABITS)) bus2 ();

    cmd_rw_arbiter #(.NREQ(NREQ), .ABITS(ABITS), .BABITS(BABITS), .TRRD(4), .TFAW(16))
        dut (.clk(clk), .rst(rst), .bus(bus));
    cmd_rw_arbiter #(.NREQ(NREQ), .ABITS(ABITS), .BABITS(BABITS), .TRRD(1), .TFAW(16))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int cnt  [NREQ];
    int cnt2 [NREQ];
    logic [NREQ-1:0]  act_mask;
    logic [PW-1:0]    exp_q [$];
    int               g_cyc [$];
    int               g_idx [$];
    int               g2_cyc [$];
    int               g2_idx [$];
    logic             cv_log [64];
    logic             rg_log [64];
    logic [ABITS-1:0] pa_log [64];
    logic [PW-1:0]    mon_obs;
    logic [PW-1:0]    mon_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // {a, ba, cas, ras, we, is_cmd, is_read, is_write, is_mw}
    function automatic logic [PW-1:0] pay(input int i, input logic act);
        logic [ABITS-1:0]  a;
        logic [BABITS-1:0] ba;
        logic              wr;
        a  = ABITS'(32'h1000 + i * 273);
        ba = BABITS'(i);
        wr = i[0];
        if (act) return {a, ba, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        return {a, ba, 1'b1, 1'b0, wr, 1'b1, ~wr, wr, 1'b0};
    endfunction

    task automatic drive();
        logic [PW-1:0] p;
        for (int i = 0; i < NREQ; i++) begin
            p = pay(i, act_mask[i]);
            bus.req_a[i*ABITS +: ABITS]    = p[10 +: ABITS];
            bus.req_ba[i*BABITS +: BABITS] = p[7 +: BABITS];
            bus.req_cas[i]      = p[6];
            bus.req_ras[i]      = p[5];
            bus.req_we[i]       = p[4];
            bus.req_is_cmd[i]   = p[3];
            bus.req_is_read[i]  = p[2];
            bus.req_is_write[i] = p[1];
            bus.req_is_mw[i]    = p[0];
            bus.req_valid[i]    = (cnt[i] != 0);
            p = pay(i, 1'b1);
            bus2.req_a[i*ABITS +: ABITS]    = p[10 +: ABITS];
            bus2.req_ba[i*BABITS +: BABITS] = p[7 +: BABITS];
            bus2.req_cas[i]      = p[6];
            bus2.req_ras[i]      = p[5];
            bus2.req_we[i]       = p[4];
            bus2.req_is_cmd[i]   = p[3];
            bus2.req_is_read[i]  = p[2];
            bus2.req_is_write[i] = p[1];
            bus2.req_is_mw[i]    = p[0];
            bus2.req_valid[i]    = (cnt2[i] != 0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (cyc < 64) begin
            cv_log[cyc] = bus.cmd_valid;
            rg_log[cyc] = bus.refresh_gnt;
            pa_log[cyc] = bus.cmd_payload_a;
        end
        if (!rst) begin
            if (|bus.req_ready) begin
                chk("ready_onehot", 64'($onehot(bus.req_ready)), 64'd1);
                chk("ready_without_valid", 64'(bus.req_ready & ~bus.req_valid), 64'd0);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    g_cyc.push_back(cyc);
                    g_idx.push_back(i);
                    cnt[i]--;
                end
                if (bus2.req_valid[i] && bus2.req_ready[i]) begin
                    g2_cyc.push_back(cyc);
                    g2_idx.push_back(i);
                    cnt2[i]--;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            cnt[i]  = 0;
            cnt2[i] = 0;
        end
        act_mask         = '0;
        bus.cmd_ready    = 1'b0;
        bus.refresh_req  = 1'b0;
        bus2.cmd_ready   = 1'b1;
        bus2.refresh_req = 1'b0;
        drive();
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
        g_cyc.delete();
        g_idx.delete();
        g2_cyc.delete();
        g2_idx.delete();
    endtask

    task automatic expect_req(input int i);
        exp_q.push_back(pay(i, act_mask[i]));
    endtask

    task automatic chk_grant(input string name, input int k, input int ec, input int ei);
        chk({name, "_cycle"}, 64'((k < g_cyc.size()) ? g_cyc[k] : -1), 64'(ec));
        chk({name, "_index"}, 64'((k < g_idx.size()) ? g_idx[k] : -1), 64'(ei));
    endtask

    // Scoreboard monitor: every output handshake consumes one expected payload
    always @(negedge clk) begin
        if (!rst && bus.cmd_valid && bus.cmd_ready) begin
            mon_obs = {bus.cmd_payload_a, bus.cmd_payload_ba, bus.cmd_payload_cas,
                       bus.cmd_payload_ras, bus.cmd_payload_we, bus.cmd_payload_is_cmd,
                       bus.cmd_payload_is_read, bus.cmd_payload_is_write, bus.cmd_payload_is_mw};
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL cmd_unexpected: got %0h, expected no command", mon_obs);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("cmd_payload", 64'(mon_obs), 64'(mon_exp));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        chk("reset_cmd_valid", 64'(bus.cmd_valid), 64'd0);
        chk("reset_refresh_gnt", 64'(bus.refresh_gnt), 64'd0);
        chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
        chk("reset_payload_a", 64'(bus.cmd_payload_a), 64'd0);

        // 1: all requesters, non-ACT, continuous cmd_ready
        do_reset();
        cnt[0] = 2;
        for (int i = 1; i < NREQ; i++) cnt[i] = 1;
        bus.cmd_ready = 1'b1;
        drive();
        for (int i = 0; i < 9; i++) expect_req(i % NREQ);
        repeat (12) tick();
        chk("t1_grant_count", 64'(g_idx.size()), 64'd9);
        for (int k = 0; k < 9; k++) chk_grant("t1_grant", k, k, k % NREQ);
        chk("t1_valid_c0", 64'(cv_log[0]), 64'd0);
        for (int c = 1; c < 10; c++) chk("t1_valid_stream", 64'(cv_log[c]), 64'd1);
        chk("t1_valid_c10", 64'(cv_log[10]), 64'd0);

        // 2: backpressure holds payload, release grants in the handshake cycle
        do_reset();
        cnt[0] = 1;
        cnt[1] = 1;
        drive();
        expect_req(0);
        expect_req(1);
        for (int k = 0; k < 10; k++) begin
            if (cyc == 6) bus.cmd_ready = 1'b1;
            tick();
        end
        chk("t2_grant_count", 64'(g_idx.size()), 64'd2);
        chk_grant("t2_grant0", 0, 0, 0);
        chk_grant("t2_grant1", 1, 6, 1);
        for (int c = 1; c < 6; c++) begin
            chk("t2_hold_valid", 64'(cv_log[c]), 64'd1);
            chk("t2_hold_a", 64'(pa_log[c]), 64'(ABITS'(32'h1000)));
        end
        chk("t2_valid_c7", 64'(cv_log[7]), 64'd1);
        chk("t2_valid_c8", 64'(cv_log[8]), 64'd0);

        // 3: TRRD=4, ACT on 0..3, non-ACT requester 4 fills the gaps
        do_reset();
        act_mask = 8'h0F;
        for (int i = 0; i < 4; i++) cnt[i] = 1;
        cnt[4] = 3;
        bus.cmd_ready = 1'b1;
        drive();
        expect_req(0); expect_req(4); expect_req(4); expect_req(4);
        expect_req(1); expect_req(2); expect_req(3);
        repeat (16) tick();
        chk("t3_grant_count", 64'(g_idx.size()), 64'd7);
        chk_grant("t3_act0", 0, 0, 0);
        chk_grant("t3_gap1", 1, 1, 4);
        chk_grant("t3_gap2", 2, 2, 4);
        chk_grant("t3_gap3", 3, 3, 4);
        chk_grant("t3_act1", 4, 4, 1);
        chk_grant("t3_act2", 5, 8, 2);
        chk_grant("t3_act3", 6, 12, 3);

        // 4: TRRD=1, TFAW=16, ACT from all eight requesters
        do_reset();
        for (int i = 0; i < NREQ; i++) cnt2[i] = 1;
        drive();
        repeat (24) tick();
        chk("t4_grant_count", 64'(g2_idx.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            chk("t4_faw_cycle", 64'((k < g2_cyc.size()) ? g2_cyc[k] : -1),
                64'((k < 4) ? k : 12 + k));
            chk("t4_faw_index", 64'((k < g2_idx.size()) ? g2_idx[k] : -1), 64'(k));
        end

        // 5: refresh while a command is stalled downstream
        do_reset();
        cnt[0] = 1;
        drive();
        expect_req(0);
        expect_req(1);
        for (int k = 0; k < 14; k++) begin
            if (cyc == 2) begin
                bus.refresh_req = 1'b1;
                cnt[1] = 1;
                drive();
            end
            if (cyc == 5) bus.cmd_ready = 1'b1;
            if (cyc == 8) bus.refresh_req = 1'b0;
            tick();
        end
        chk("t5_grant_count", 64'(g_idx.size()), 64'd2);
        chk_grant("t5_grant0", 0, 0, 0);
        chk_grant("t5_resume", 1, 9, 1);
        for (int c = 2; c < 6; c++) chk("t5_gnt_low", 64'(rg_log[c]), 64'd0);
        for (int c = 6; c < 9; c++) chk("t5_gnt_high", 64'(rg_log[c]), 64'd1);
        chk("t5_gnt_drop", 64'(rg_log[9]), 64'd0);
        chk("t5_valid_in_refresh", 64'(cv_log[7]), 64'd0);
        chk("t5_valid_after", 64'(cv_log[10]), 64'd1);

        // 5b: refresh and a request in the same cycle, output idle
        do_reset();
        cnt[2] = 1;
        bus.refresh_req = 1'b1;
        bus.cmd_ready = 1'b1;
        drive();
        expect_req(2);
        for (int k = 0; k < 8; k++) begin
            if (cyc == 3) bus.refresh_req = 1'b0;
            tick();
        end
        chk("t5b_gnt_c1", 64'(rg_log[1]), 64'd0);
        chk("t5b_gnt_c2", 64'(rg_log[2]), 64'd1);
        chk("t5b_gnt_c3", 64'(rg_log[3]), 64'd1);
        chk("t5b_gnt_c4", 64'(rg_log[4]), 64'd0);
        chk("t5b_grant_count", 64'(g_idx.size()), 64'd1);
        chk_grant("t5b_grant", 0, 4, 2);

        // 6: reset with a stalled command, then reset while refresh is granted
        do_reset();
        cnt[3] = 1;
        drive();
        for (int k = 0; k < 11; k++) begin
            if (cyc == 2) rst = 1'b1;
            if (cyc == 3) begin
                rst = 1'b0;
                bus.refresh_req = 1'b1;
            end
            if (cyc == 5) begin
                rst = 1'b1;
                cnt[0] = 1;
                cnt[5] = 1;
                drive();
                expect_req(0);
                expect_req(5);
            end
            if (cyc == 6) begin
                rst = 1'b0;
                bus.refresh_req = 1'b0;
                bus.cmd_ready = 1'b1;
            end
            tick();
        end
        chk("t6_valid_before_rst", 64'(cv_log[2]), 64'd1);
        chk("t6_valid_after_rst", 64'(cv_log[3]), 64'd0);
        chk("t6_payload_after_rst", 64'(pa_log[3]), 64'd0);
        chk("t6_gnt_before_rst", 64'(rg_log[5]), 64'd1);
        chk("t6_gnt_after_rst", 64'(rg_log[6]), 64'd0);
        chk("t6_grant_count", 64'(g_idx.size()), 64'd3);
        chk_grant("t6_first", 0, 0, 3);
        chk_grant("t6_req0_wins", 1, 6, 0);
        chk_grant("t6_next", 2, 7, 5);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmd_rw_arbiter.md
# cmd_rw_arbiter

- Shares the single `cmd_rw_interface` command stream between NREQ bank machines.
- Each cycle it picks one eligible requester in round-robin order and latches its command into a registered output stage.
- Activates (ACT) are held back until tRRD and tFAW allow them.
- Normal traffic is drained and frozen while the refresher holds `refresh_req`.
- Sits between the per-bank command queues and the multiplexer that drives the DFI LPDDR4 phases.

## Interface

Parameters:
- `NREQ`, 8, number of requesters (bank machines)
- `ABITS`, 17, command address width
- `BABITS`, 3, bank address width
- `TRRD`, 4, minimum cycles between two ACT grants (≥1)
- `TFAW`, 16, rolling window in which at most 4 ACT grants are allowed (≥2)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NREQ  per-requester command valid
- `req_ready`  out  NREQ  per-requester accept (combinational)
- `req_a`  in  NREQ*ABITS  packed addresses, requester i at bits [i*ABITS +: ABITS]
- `req_ba`  in  NREQ*BABITS  packed bank addresses
- `req_cas`, `req_ras`, `req_we`, `req_is_cmd`, `req_is_read`, `req_is_write`, `req_is_mw`  in  NREQ each  per-requester flags
- `cmd_valid`  out  1  output command valid (registered)
- `cmd_ready`  in  1  downstream accept
- `cmd_payload_a`  out  ABITS; `cmd_payload_ba`  out  BABITS
- `cmd_payload_cas`, `_ras`, `_we`, `_is_cmd`, `_is_read`, `_is_write`, `_is_mw`  out  1 each
- `refresh_req`  in  1  refresher requests exclusive ownership
- `refresh_gnt`  out  1  ownership granted (registered)

## Operation

**Command classes**
- ACT: `is_cmd & ras & ~cas & ~we`. Every other command ignores the timers.

**Eligibility**
- Requester i is eligible iff `req_valid[i]` and (not ACT or `act_ok`).
- `act_ok` = (`trrd_cnt`==0) and (ACT grants in the previous TFAW-1 cycles < 4).

**Output stage**
- `out_free` = `~cmd_valid | cmd_ready`.

**States**
- ARB
  - If `refresh_req` → DRAIN. Nothing is granted this cycle, even with eligible requesters present.
  - Else if `out_free` and any requester is eligible: grant the first eligible index after `last_grant`, wrapping modulo NREQ.
  - On grant: `req_ready[grant]`=1, load the payload into the output, `cmd_valid`←1, `last_grant`←grant.
  - Else if `cmd_ready`: `cmd_valid`←0.
- DRAIN
  - No grants.
  - When `cmd_valid` is 0, or `cmd_ready` is 1 this cycle: clear `cmd_valid`, set `refresh_gnt`←1, go to REFRESH.
  - If `refresh_req` drops while in DRAIN, return to ARB without asserting `refresh_gnt`.
- REFRESH
  - `refresh_gnt` held at 1, `cmd_valid` held at 0.
  - When `refresh_req`=0: `refresh_gnt`←0, go to ARB. Grants resume the following cycle.

**Output rules**
- Payload and `cmd_valid` must not change while `cmd_valid & ~cmd_ready`.
- At most one `req_ready` bit is high per cycle.
- `req_ready` never asserts when `req_valid` is low.

**Timers** (both advance every cycle, in all states)
- `trrd_cnt`: loads TRRD-1 on an ACT grant, otherwise decrements and saturates at 0.
- `faw_hist`: TFAW-1 bit shift register; shifts in 1 on an ACT grant, else 0. `act_ok` requires popcount < 4.

**Reset**
- `cmd_valid`=0, `refresh_gnt`=0, `req_ready`=0.
- Payload outputs cleared to 0.
- `last_grant`=NREQ-1, so requester 0 has first priority.
- State ARB; `trrd_cnt`=0; `faw_hist`=0.
- Asserting `rst` mid-transfer drops any pending output command.

## Timing

- Latency: grant (`req_valid[i] & req_ready[i]`) in cycle t gives `cmd_valid`=1 in cycle t+1.
- Throughput: one command per cycle under continuous `cmd_ready`.
- ACT spacing: ACT grants at cycle t and t' require t'−t ≥ TRRD.
- ACT density: any TFAW consecutive cycles contain at most 4 ACT grants.
- A blocked ACT does not block other requesters: a non-ACT requester behind it in round-robin order is granted the same cycle.
- Refresh, with `cmd_valid` low: `refresh_req` rising at cycle t gives `refresh_gnt`=1 at cycle t+2 at the earliest (ARB→DRAIN, then DRAIN→REFRESH).
- `refresh_req` and a request arriving in the same cycle: refresh wins, and the request is not granted.
- `refresh_gnt` falls one cycle after `refresh_req` falls.

## Structure

- Shared package `lpddr4_ctrl_pkg`:
  - `cmd_payload_t` packed struct (a, ba, cas, ras, we, is_cmd, is_read, is_write, is_mw)
  - `arb_state_e` enum (ARB, DRAIN, REFRESH)
  - function `is_activate(cmd_payload_t)`
- Sub-module `rr_arbiter #(N)`:
  - inputs: request vector, `last_grant`
  - outputs: one-hot grant and grant index
  - purely combinational rotate-priority-encode

## Test plan

1. Reset, then `req_valid`=8'hFF with all non-ACT commands and `cmd_ready`=1 → grants in order 0,1,…,7,0; `cmd_valid` high from cycle 2 onward; each payload matches its requester.
2. `cmd_ready`=0 for 5 cycles with one command loaded → payload stable, no further `req_ready`. Release → next grant in the same cycle as the handshake.
3. TRRD=4, requesters 0–3 all ACT → ACT grants at t, t+4, t+8, t+12. A non-ACT requester 4 is granted in the gap cycles.
4. TRRD=1, TFAW=16, continuous ACT from 8 requesters → 4 grants in consecutive cycles, then no ACT grant until 16 cycles after the first.
5. Command in flight with `cmd_ready`=0, then `refresh_req`=1 → no new grants; `refresh_gnt`=1 the cycle after `cmd_ready` handshakes. `refresh_req`=0 → `gnt` drops next cycle and grants resume after that.
6. `rst` asserted while `cmd_valid`=1 and `refresh_gnt`=1 → next cycle all outputs 0 and requester 0 wins the first grant.
